// File: rtl/mem_issue_queue_pkg.sv
// Shared definitions for the memory issue queue: uop packet layout, bypass bus
// layout and the branch-kill predicate also used by the AGU and sibling queues.
package mem_issue_queue_pkg;

  localparam int IQ_WIDTH_BRM = 4;
  localparam int IQ_WIDTH_REG = 5;
  localparam int IQ_WIDTH     = 2 + 7 + IQ_WIDTH_BRM + IQ_WIDTH_REG + 10 + 4 * 32;
  localparam int IQ_BYP_W     = 33 + IQ_WIDTH_REG;

  // Field order, MSB first: {val, uop, brmask, rd, pc, func, imm, op2, op1}.
  typedef struct packed {
    logic                    val;
    logic [7:0]              uop;
    logic [IQ_WIDTH_BRM-1:0] brmask;
    logic [IQ_WIDTH_REG-1:0] rd;
    logic [31:0]             pc;
    logic [9:0]              func;
    logic [31:0]             imm;
    logic [31:0]             op2;
    logic [31:0]             op1;
  } uop_pkt_t;

  typedef struct packed {
    logic                    val;
    logic [IQ_WIDTH_REG-1:0] tag;
    logic [31:0]             data;
  } bypass_t;

  function automatic logic killf(input logic [IQ_WIDTH_BRM-1:0]    brmask,
                                 input logic [2**IQ_WIDTH_BRM-1:0] brkill);
    return brkill[brmask];
  endfunction

endpackage

// File: rtl/mem_iq_entry.sv
// One issue-queue slot: holds a uop plus its operand readiness, snoops both
// bypass buses and reports post-wakeup readiness and same-cycle kill to the head.
module mem_iq_entry
  import mem_issue_queue_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic                      pop,
  input  uop_pkt_t                  instr,
  input  logic [IQ_WIDTH_REG-1:0]   rs1,
  input  logic [IQ_WIDTH_REG-1:0]   rs2,
  input  logic                      rdy1,
  input  logic                      rdy2,
  input  bypass_t                   byp0,
  input  bypass_t                   byp1,
  input  logic [2**IQ_WIDTH_BRM-1:0] brkill,
  output logic                      valid,
  output logic                      ready,
  output logic                      kill,
  output uop_pkt_t                  pkt
);

  logic                    valid_q, rdy1_q, rdy2_q;
  logic [IQ_WIDTH_REG-1:0] rs1_q, rs2_q;
  uop_pkt_t                pkt_q;

  logic                    live, s_rdy1, s_rdy2;
  logic [IQ_WIDTH_REG-1:0] s_rs1, s_rs2;
  logic                    h1_0, h1_1, h2_0, h2_1;
  logic                    w_rdy1, w_rdy2;
  uop_pkt_t                s_pkt, w_pkt;

  // An entry being written this cycle snoops the buses with the dispatch values.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    live   = we | valid_q;
    s_rdy1 = we ? rdy1  : rdy1_q;
    s_rdy2 = we ? rdy2  : rdy2_q;
    s_rs1  = we ? rs1   : rs1_q;
    s_rs2  = we ? rs2   : rs2_q;
    s_pkt  = we ? instr : pkt_q;

    h1_0 = live && !s_rdy1 && byp0.val && (byp0.tag == s_rs1);
    h1_1 = live && !s_rdy1 && byp1.val && (byp1.tag == s_rs1);
    h2_0 = live && !s_rdy2 && byp0.val && (byp0.tag == s_rs2);
    h2_1 = live && !s_rdy2 && byp1.val && (byp1.tag == s_rs2);

    w_pkt = s_pkt;
    if (h1_0)      w_pkt.op1 = byp0.data;
    else if (h1_1) w_pkt.op1 = byp1.data;
    if (h2_0)      w_pkt.op2 = byp0.data;
    else if (h2_1) w_pkt.op2 = byp1.data;

    w_rdy1 = s_rdy1 | h1_0 | h1_1;
    w_rdy2 = s_rdy2 | h2_0 | h2_1;
    kill   = live && killf(s_pkt.brmask, brkill);
  end

  assign valid = valid_q;
  assign ready = w_rdy1 & w_rdy2;
  assign pkt   = w_pkt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      valid_q <= 1'b0;
      rdy1_q  <= 1'b0;
      rdy2_q  <= 1'b0;
    end else begin
      valid_q <= live && !kill && !pop;
      rdy1_q  <= w_rdy1;
      rdy2_q  <= w_rdy2;
    end
  end

  // NOTE: payload storage is not reset; valid gates it, so reset only the control bits.
  always_ff @(posedge clk) begin
    rs1_q <= s_rs1;
    rs2_q <= s_rs2;
    pkt_q <= w_pkt;
  end

endmodule

// File: rtl/mem_issue_queue.sv
// In-order memory issue queue: circular buffer of mem_iq_entry slots, issues the
// oldest entry once both operands are ready, into a registered AGU packet.
module mem_issue_queue
  import mem_issue_queue_pkg::*;
#(
  parameter int DEPTH_W   = 3,
  parameter int WIDTH_BRM = IQ_WIDTH_BRM,
  parameter int WIDTH_REG = IQ_WIDTH_REG,
  parameter int WIDTH     = 2 + 7 + WIDTH_BRM + WIDTH_REG + 10 + 4 * 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_we,
  input  logic [WIDTH-1:0]        i_instr,
  input  logic [WIDTH_REG-1:0]    i_rs1,
  input  logic [WIDTH_REG-1:0]    i_rs2,
  input  logic                    i_rdy1,
  input  logic                    i_rdy2,
  output logic                    o_full,
  input  logic [33+WIDTH_REG-1:0] i_bypass0,
  input  logic [33+WIDTH_REG-1:0] i_bypass1,
  input  logic [2**WIDTH_BRM-1:0] i_brkill,
  output logic [WIDTH-1:0]        o_instr
);

  localparam int                 DEPTH    = 2 ** DEPTH_W;
  localparam logic [DEPTH_W:0]   FULL_CNT = (DEPTH_W + 1)'(DEPTH);

  logic [DEPTH_W-1:0] head_q, tail_q;
  logic [DEPTH_W:0]   count_q;
  uop_pkt_t           out_q;

  logic [DEPTH-1:0]   e_we, e_pop, e_valid, e_ready, e_kill;
  uop_pkt_t           e_pkt [DEPTH];
  uop_pkt_t           in_pkt, head_pkt;
  bypass_t            byp0, byp1;
  logic               enq, pop, issue;
  logic               head_valid, head_ready, head_kill;

  assign in_pkt = i_instr;
  assign byp0   = i_bypass0;
  assign byp1   = i_bypass1;
  assign o_full = (count_q == FULL_CNT);

  always_comb begin
    head_valid = e_valid[head_q];
    head_ready = e_ready[head_q];
    head_kill  = e_kill[head_q];
    head_pkt   = e_pkt[head_q];
    enq        = i_we && !o_full;
    // A dead head is drained without issue; a killed-this-cycle head holds once.
    pop        = (count_q != '0) && (!head_valid || (!head_kill && head_ready));
    issue      = pop && head_valid;
    e_we          = '0;
    e_we[tail_q]  = enq;
    e_pop         = '0;
    e_pop[head_q] = pop;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    mem_iq_entry u_entry (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .we     (e_we[g]),
      .pop    (e_pop[g]),
      .instr  (in_pkt),
      .rs1    (i_rs1),
      .rs2    (i_rs2),
      .rdy1   (i_rdy1),
      .rdy2   (i_rdy2),
      .byp0   (byp0),
      .byp1   (byp1),
      .brkill (i_brkill),
      .valid  (e_valid[g]),
      .ready  (e_ready[g]),
      .kill   (e_kill[g]),
      .pkt    (e_pkt[g])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + DEPTH_W'(pop);
      tail_q  <= tail_q + DEPTH_W'(enq);
      count_q <= count_q + (DEPTH_W + 1)'(enq) - (DEPTH_W + 1)'(pop);
    end
  end

  // Issued operands are post-wakeup, so a same-cycle bypass reaches the AGU directly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_q <= '0;
    end else if (issue) begin
      out_q     <= head_pkt;
      out_q.val <= 1'b1;
    end else begin
      out_q.val <= 1'b0;
    end
  end

  assign o_instr = out_q;

endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed and randomized bench for mem_issue_queue against a queue-based
// reference model of in-order issue, wakeup and branch kill.
module tb_mem_issue_queue;
  import mem_issue_queue_pkg::*;

  logic                        i_clk = 1'b0;
  logic                        i_rst_n;
  logic                        i_we;
  logic [IQ_WIDTH-1:0]         i_instr;
  logic [IQ_WIDTH_REG-1:0]     i_rs1, i_rs2;
  logic                        i_rdy1, i_rdy2;
  logic                        o_full;
  logic [IQ_BYP_W-1:0]         i_bypass0, i_bypass1;
  logic [2**IQ_WIDTH_BRM-1:0]  i_brkill;
  logic [IQ_WIDTH-1:0]         o_instr;

  always #5 i_clk = ~i_clk;

  mem_issue_queue dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_we      (i_we),
    .i_instr   (i_instr),
    .i_rs1     (i_rs1),
    .i_rs2     (i_rs2),
    .i_rdy1    (i_rdy1),
    .i_rdy2    (i_rdy2),
    .o_full    (o_full),
    .i_bypass0 (i_bypass0),
    .i_bypass1 (i_bypass1),
    .i_brkill  (i_brkill),
    .o_instr   (o_instr)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit                      alive;
    bit                      r1;
    bit                      r2;
    logic [IQ_WIDTH_REG-1:0] rs1;
    logic [IQ_WIDTH_REG-1:0] rs2;
    uop_pkt_t                p;
  } ment_t;

  ment_t                   mq[$];
  logic [IQ_WIDTH_REG-1:0] issued_rd[$];
  uop_pkt_t                got;

  task automatic check(input string tag, input logic [IQ_WIDTH-1:0] obs,
                       input logic [IQ_WIDTH-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic ment_t wake(input ment_t e);
    bypass_t b0, b1;
    b0 = i_bypass0;
    b1 = i_bypass1;
    if (!e.r1) begin
      if (b0.val && b0.tag == e.rs1)      begin e.p.op1 = b0.data; e.r1 = 1'b1; end
      else if (b1.val && b1.tag == e.rs1) begin e.p.op1 = b1.data; e.r1 = 1'b1; end
    end
    if (!e.r2) begin
      if (b0.val && b0.tag == e.rs2)      begin e.p.op2 = b0.data; e.r2 = 1'b1; end
      else if (b1.val && b1.tag == e.rs2) begin e.p.op2 = b1.data; e.r2 = 1'b1; end
    end
    return e;
  endfunction

  // Advance the model with the current inputs, clock the DUT, compare outputs.
  task automatic cycle();
    bit       e_en, pop, issue;
    uop_pkt_t exp_pkt;
    ment_t    ne;
    e_en    = i_we && (mq.size() < 8);
    pop     = 1'b0;
    issue   = 1'b0;
    exp_pkt = '0;
    foreach (mq[k]) if (mq[k].alive) mq[k] = wake(mq[k]);
    if (mq.size() > 0) begin
      if (!mq[0].alive) pop = 1'b1;
      else if (!i_brkill[mq[0].p.brmask] && mq[0].r1 && mq[0].r2) begin
        pop = 1'b1;
        issue = 1'b1;
        exp_pkt = mq[0].p;
        exp_pkt.val = 1'b1;
      end
    end
    foreach (mq[k]) if (mq[k].alive && i_brkill[mq[k].p.brmask]) mq[k].alive = 1'b0;
    if (pop) void'(mq.pop_front());
    if (e_en) begin
      ne.alive = 1'b1;
      ne.r1 = i_rdy1;
      ne.r2 = i_rdy2;
      ne.rs1 = i_rs1;
      ne.rs2 = i_rs2;
      ne.p = i_instr;
      ne = wake(ne);
      if (i_brkill[ne.p.brmask]) ne.alive = 1'b0;
      mq.push_back(ne);
    end
    @(posedge i_clk);
    #1;
    check("o_full", o_full, mq.size() == 8);
    check("issue_val", o_instr[IQ_WIDTH-1], issue);
    if (issue) check("issue_pkt", o_instr, exp_pkt);
    got = o_instr;
    if (got.val) issued_rd.push_back(got.rd);
  endtask

  task automatic idle();
    i_we = 0; i_instr = '0; i_rs1 = '0; i_rs2 = '0; i_rdy1 = 0; i_rdy2 = 0;
    i_bypass0 = '0; i_bypass1 = '0; i_brkill = '0;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  function automatic uop_pkt_t mk(input logic [IQ_WIDTH_BRM-1:0] brm,
                                  input logic [IQ_WIDTH_REG-1:0] rd, input bit store);
    uop_pkt_t p;
    p.val = 1'b0;
    p.uop = store ? 8'h02 : 8'h01;
    p.brmask = brm;
    p.rd = rd;
    p.pc = $urandom;
    p.func = 10'($urandom);
    p.imm = $urandom;
    p.op1 = $urandom;
    p.op2 = $urandom;
    return p;
  endfunction

  function automatic logic [IQ_BYP_W-1:0] byp(input logic [IQ_WIDTH_REG-1:0] tag,
                                               input logic [31:0] data);
    return {1'b1, tag, data};
  endfunction

  task automatic do_enq(input uop_pkt_t p, input logic r1, input logic r2,
                        input logic [IQ_WIDTH_REG-1:0] rs1, input logic [IQ_WIDTH_REG-1:0] rs2);
    i_we = 1; i_instr = p; i_rdy1 = r1; i_rdy2 = r2; i_rs1 = rs1; i_rs2 = rs2;
    cycle();
    i_we = 0; i_rdy1 = 0; i_rdy2 = 0;
  endtask

  initial begin
    i_rst_n = 1'b0;
    idle();
    #12;
    check("rst_instr", o_instr, '0);
    check("rst_full", o_full, 1'b0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Reset then fill: eight ready loads issue in order, one per cycle.
    issued_rd.delete();
    for (int r = 1; r <= 8; r++) do_enq(mk(0, 5'(r), 0), 1, 1, 0, 0);
    run(3);
    check("fill_cnt", issued_rd.size(), 8);
    for (int i = 0; i < 8 && i < issued_rd.size(); i++) check("fill_rd", issued_rd[i], i + 1);

    // Operand wakeup three cycles after enqueue.
    issued_rd.delete();
    do_enq(mk(0, 20, 1), 1, 0, 0, 7);
    run(2);
    check("wake_early", issued_rd.size(), 0);
    i_bypass0 = byp(7, 32'hDEADBEEF);
    cycle();
    i_bypass0 = '0;
    got = o_instr;
    check("wake_val", got.val, 1'b1);
    check("wake_op2", got.op2, 32'hDEADBEEF);

    // Head blocking: ready B waits behind blocked A.
    issued_rd.delete();
    do_enq(mk(0, 21, 0), 0, 1, 9, 0);
    do_enq(mk(0, 22, 0), 1, 1, 0, 0);
    run(3);
    check("block_none", issued_rd.size(), 0);
    i_bypass1 = byp(9, 32'h12345678);
    cycle();
    i_bypass1 = '0;
    run(2);
    check("block_cnt", issued_rd.size(), 2);
    if (issued_rd.size() == 2) begin
      check("block_a", issued_rd[0], 21);
      check("block_b", issued_rd[1], 22);
    end

    // Branch kill of brmask 2 entries; only brmask 5 survives.
    issued_rd.delete();
    do_enq(mk(2, 23, 0), 0, 1, 11, 0);
    do_enq(mk(2, 24, 0), 0, 1, 11, 0);
    do_enq(mk(5, 25, 0), 0, 1, 11, 0);
    i_brkill = 16'h0004;
    cycle();
    i_brkill = '0;
    run(3);
    i_bypass0 = byp(11, 32'h00000BBB);
    cycle();
    i_bypass0 = '0;
    run(2);
    check("kill_cnt", issued_rd.size(), 1);
    if (issued_rd.size() == 1) check("kill_rd", issued_rd[0], 25);

    // Full, dropped write, then wrap with four more.
    issued_rd.delete();
    for (int r = 10; r < 18; r++) do_enq(mk(0, 5'(r), 0), 0, 1, 12, 0);
    check("full_set", o_full, 1'b1);
    do_enq(mk(0, 30, 0), 1, 1, 0, 0);
    check("full_drop", o_full, 1'b1);
    i_bypass0 = byp(12, 32'hCAFE0000);
    cycle();
    i_bypass0 = '0;
    for (int r = 18; r < 22; r++) do_enq(mk(0, 5'(r), 0), 1, 1, 0, 0);
    run(10);
    check("wrap_cnt", issued_rd.size(), 12);
    for (int i = 0; i < 12 && i < issued_rd.size(); i++) check("wrap_rd", issued_rd[i], 10 + i);

    // Same-cycle bypass at enqueue.
    issued_rd.delete();
    i_bypass1 = byp(3, 32'h10);
    do_enq(mk(0, 26, 0), 0, 1, 3, 0);
    i_bypass1 = '0;
    cycle();
    got = o_instr;
    check("enqbyp_val", got.val, 1'b1);
    check("enqbyp_op1", got.op1, 32'h10);

    // Randomized traffic against the model.
    repeat (400) begin
      i_we      = ($urandom_range(0, 3) != 0);
      i_instr   = mk(4'($urandom_range(0, 15)), 5'($urandom), 1'($urandom_range(0, 1)));
      i_rdy1    = 1'($urandom_range(0, 1));
      i_rdy2    = 1'($urandom_range(0, 1));
      i_rs1     = 5'($urandom_range(0, 7));
      i_rs2     = 5'($urandom_range(0, 7));
      i_bypass0 = ($urandom_range(0, 2) == 0) ? byp(5'($urandom_range(0, 7)), $urandom) : '0;
      i_bypass1 = ($urandom_range(0, 2) == 0) ? byp(5'($urandom_range(0, 7)), $urandom) : '0;
      i_brkill  = ($urandom_range(0, 15) == 0) ? 16'(1 << $urandom_range(0, 15)) : '0;
      cycle();
    end
    idle();

    // Asynchronous reset from a full queue.
    for (int i = 0; i < 16 && mq.size() < 8; i++) do_enq(mk(0, 27, 0), 0, 0, 30, 30);
    check("pre_rst_full", o_full, 1'b1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_instr", o_instr, '0);
    check("arst_full", o_full, 1'b0);
    mq.delete();
    #3;
    i_rst_n = 1'b1;
    issued_rd.delete();
    do_enq(mk(0, 28, 0), 1, 1, 0, 0);
    cycle();
    check("post_rst_cnt", issued_rd.size(), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_issue_queue.md
# mem_issue_queue

In-order issue queue for memory micro-ops; sits directly upstream of the AGU and drives its `i_instr` input. Dispatch writes load/store uops whose source operands may still be outstanding. The queue captures operand values from the writeback bypass buses, then issues the oldest entry once its operands are ready. It also discards entries on branch kill. Issue is strictly in program order, so the LSQ never sees memory ops out of order.

## Interface
Parameters:
- `DEPTH_W`, 3, log2 of entry count (8 entries)
- `WIDTH_BRM`, 4, branch-mask index width
- `WIDTH_REG`, 5, physical register tag width
- `WIDTH`, 2+7+WIDTH_BRM+WIDTH_REG+10+4*32, uop packet width, packed as {val, uop, brmask, rd, pc, func, imm, op2, op1}

Ports:
- `i_clk` in 1: clock, single clock domain, rising edge
- `i_rst_n` in 1: asynchronous active-low reset
- `i_we` in 1: dispatch enqueue strobe
- `i_instr` in WIDTH: dispatched uop packet; op1/op2 are valid only where the matching ready bit is set
- `i_rs1`, `i_rs2` in WIDTH_REG: source tags for op1 and op2
- `i_rdy1`, `i_rdy2` in 1: operand already valid at dispatch; dispatch sets `i_rdy2`=1 for loads
- `o_full` out 1: queue full; dispatch must not assert `i_we`
- `i_bypass0`, `i_bypass1` in 33+WIDTH_REG: {val, tag, data[31:0]} wakeup buses
- `i_brkill` in 2**WIDTH_BRM: one-hot or multi-hot mispredicted branch IDs
- `o_instr` out WIDTH: registered uop to AGU; its val field is the issue-valid bit

## Operation
- Storage is a circular FIFO: `head`, `tail` (DEPTH_W bits, wrap naturally), and `count` (DEPTH_W+1 bits).
- Per-entry state: valid, rdy1, rdy2, rs1, rs2, packet.
- **Enqueue:** when `i_we && !o_full`, write at `tail`, set valid=1, then `tail++`. If `i_we` is asserted while full, the write is dropped and the state does not change.
- **Wakeup:** for every valid entry and each bypass bus with val=1, when tag==rsN and rdyN==0, write the bus data into opN and set rdyN=1.
  - An entry being enqueued in the same cycle also compares against both buses and captures the data.
  - If both buses match the same operand, bus0 wins.
- **Kill:** an entry dies when `i_brkill[brmask]`=1; use the shared `killf`. Dying clears valid but does not free the slot.
- **Head processing (one per cycle):**
  - Head invalid and count>0: pop it, with no issue.
  - Head valid, not killed this cycle, and rdy1&&rdy2 (including readiness gained by same-cycle wakeup): pop it and issue.
  - Otherwise: hold.
- **Issue:** `o_instr` is loaded with the head packet with val forced to 1. Operands are taken post-wakeup, so a same-cycle bypass value is forwarded. In every non-issue cycle the val field of `o_instr` is 0; the other fields are don't-care.
- **Count:** next count = count + enq − pop. Simultaneous enqueue and pop when count==2**DEPTH_W is impossible because the enqueue is blocked.
- `o_full` = (count == 2**DEPTH_W), combinational from registered count.

## Timing
- **Reset:** while `i_rst_n`=0, and asynchronously on assertion:
  - head=tail=count=0
  - all entry valid/rdy bits 0
  - `o_instr`=0, `o_full`=0
- **Latency:** a uop enqueued at edge N into an empty queue, with both operands ready, appears on `o_instr` (val=1) after edge N+1.
- **Wakeup:** a bypass at edge M makes the entry issuable at edge M. If the entry is at the head, `o_instr` is valid after edge M.
- **Throughput:** at most one issue per cycle. Killed and invalid heads each consume one cycle.
- **No backpressure:** there is no backpressure from the AGU; an issued packet is presented for exactly one cycle.
- **Kill on the output register:** a kill in the cycle after issue is not applied to `o_instr`; the AGU applies `killf` itself.

## Structure
- Shared package: packet field offsets, the `WIDTH` expression, bypass field layout, and `killf`. These are shared with the AGU and the other issue queues.
- One natural sub-module: `mem_iq_entry`, a single entry with valid/ready/tag state and wakeup/kill compare logic, instantiated 2**DEPTH_W times.
- The queue top holds the pointers, count, head mux, and `o_instr` register, built on the common `register` primitive.

## Test plan
- **Reset then fill:** enqueue 8 ready loads (rd=1..8).
  - `o_full`=1 after the 8th edge only if no issue occurred. In practice issue starts the cycle after the first enqueue.
  - `o_instr` val=1 with rd=1..8 in order, one per cycle.
- **Operand wakeup:** enqueue a store with rdy2=0, rs2=7, then drive `i_bypass0`={1,7,32'hDEADBEEF} 3 cycles later.
  - The store issues the following cycle with op2=32'hDEADBEEF.
  - val stays 0 before that.
- **Head blocking:** enqueue a not-ready load A, then a ready load B.
  - B does not issue until A wakes up.
  - Order on `o_instr` is A then B.
- **Branch kill:** enqueue 3 uops with brmask=2, 2, 5, all blocked, then pulse `i_brkill`=16'h0004.
  - The two brmask=2 entries are popped without issue over 2 cycles.
  - After wakeup, only the brmask=5 uop issues.
- **Full and wrap:**
  - Fill to 8 with blocked heads, then assert `i_we`: the write is dropped and count stays 8.
  - Release the heads, then enqueue 4 more: pointers wrap past 7, and order and data are preserved.
- **Same-cycle bypass at enqueue:** enqueue rs1=3 with rdy1=0 while `i_bypass1`={1,3,32'h10} and `i_bypass0` is idle.
  - The entry captures op1=32'h10 and issues the next cycle.
